i2c_cfg_sequencer: RTL

//  Sequences a fixed table of codec register writes through the I2C transmit engine
//  (Wait/Start/Address/Ack/Data/Ack/Data/Ack/Stop datapath). On a start request it walks
//  the table and issues one 3-byte transaction per entry. It retries NACKed or timed-out

---
 rtl/i2c_cfg_sequencer_pkg.sv | 21 ++
 rtl/i2c_cfg_sequencer_rom.sv | 29 ++
 rtl/i2c_cfg_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared constants for the codec configuration sequencer: FSM state codes,
// the I2C write direction bit and a small parameter helper.
package i2c_cfg_sequencer_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    localparam logic [SEQ_STATE_W-1:0] SEQ_IDLE      = 3'd0;
    localparam logic [SEQ_STATE_W-1:0] SEQ_LOAD      = 3'd1;
    localparam logic [SEQ_STATE_W-1:0] SEQ_ISSUE     = 3'd2;
    localparam logic [SEQ_STATE_W-1:0] SEQ_WAIT_DONE = 3'd3;
    localparam logic [SEQ_STATE_W-1:0] SEQ_GAP       = 3'd4;
    localparam logic [SEQ_STATE_W-1:0] SEQ_FINISH    = 3'd5;
    localparam logic [SEQ_STATE_W-1:0] SEQ_FAIL      = 3'd6;

    localparam logic TX_WR_BIT = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_rom.sv
// Codec register table: each word is {data1,data2} for one 3-byte write.
// Indices at or beyond NUM_REGS read as zero.
module i2c_cfg_sequencer_rom #(
    parameter int unsigned NUM_REGS = 10
) (
    input  logic [3:0]  idx_i,
    output logic [15:0] word_o
);

    always_comb begin
        word_o = 16'h0000;
        if (32'(idx_i) < NUM_REGS) begin
            case (idx_i)
                4'd0:    word_o = 16'h1E00;
                4'd1:    word_o = 16'h0C00;
                4'd2:    word_o = 16'h0E42;
                4'd3:    word_o = 16'h1000;
                4'd4:    word_o = 16'h0812;
                4'd5:    word_o = 16'h0A00;
                4'd6:    word_o = 16'h0017;
                4'd7:    word_o = 16'h0217;
                4'd8:    word_o = 16'h0479;
                4'd9:    word_o = 16'h1201;
                default: word_o = 16'h0000;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the codec register table through the I2C transmit engine, one write per
// entry, retrying NACKed or timed-out entries and reporting done or error.
module i2c_cfg_sequencer
    import i2c_cfg_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 10,
    parameter logic [6:0]  DEV_ADDR       = 7'h1A,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        tx_go,
    output logic [7:0]  tx_addr,
    output logic [15:0] tx_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic        tx_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  reg_idx,
    output logic [1:0]  retry_cnt
);

    localparam int unsigned CNT_W = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX    = 4'(NUM_REGS - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    logic [SEQ_STATE_W-1:0] state_q, state_d;
    logic                   start_q;
    logic [15:0]            tx_data_q, tx_data_d;
    logic [3:0]             reg_idx_q, reg_idx_d;
    logic [1:0]             retry_cnt_q, retry_cnt_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   retry_pend_q, retry_pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic        start_edge;
    logic [15:0] rom_word;

    i2c_cfg_sequencer_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .idx_i  (reg_idx_q),
        .word_o (rom_word)
    );

    assign start_edge = start & ~start_q;

    // retry_pend remembers whether the gap now running follows a failed attempt,
    // so the gap exit knows whether to resend the same entry or advance.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        reg_idx_d    = reg_idx_q;
        retry_cnt_d  = retry_cnt_q;
        done_d       = done_q;
        error_d      = error_q;
        retry_pend_d = retry_pend_q;

        case (state_q)
            SEQ_IDLE: begin
                if (start_edge) begin
                    state_d      = SEQ_LOAD;
                    reg_idx_d    = 4'd0;
                    retry_cnt_d  = 2'd0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    retry_pend_d = 1'b0;
                end
            end
            SEQ_LOAD: begin
                tx_data_d = rom_word;
                state_d   = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                if (!tx_busy) begin
                    state_d = SEQ_WAIT_DONE;
                end
            end
            SEQ_WAIT_DONE: begin
                // A done pulse on the timeout cycle is honoured before the timeout.
                if (tx_done && !tx_nack) begin
                    retry_pend_d = 1'b0;
                    state_d      = SEQ_GAP;
                end else if ((tx_done && tx_nack) || (cnt_q == TMO_LAST)) begin
                    if (retry_cnt_q < RETRY_LIMIT) begin
                        retry_cnt_d  = retry_cnt_q + 2'd1;
                        retry_pend_d = 1'b1;
                        state_d      = SEQ_GAP;
                    end else begin
                        state_d = SEQ_FAIL;
                    end
                end
            end
            SEQ_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (retry_pend_q) begin
                        state_d = SEQ_LOAD;
                    end else if (reg_idx_q == LAST_IDX) begin
                        state_d = SEQ_FINISH;
                    end else begin
                        reg_idx_d   = reg_idx_q + 4'd1;
                        retry_cnt_d = 2'd0;
                        state_d     = SEQ_LOAD;
                    end
                end
            end
            SEQ_FINISH: begin
                done_d  = 1'b1;
                state_d = SEQ_IDLE;
            end
            SEQ_FAIL: begin
                error_d = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // One counter serves both the response timeout and the inter-transaction gap;
    // it restarts from zero whenever the state changes.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) &&
            ((state_q == SEQ_WAIT_DONE) || (state_q == SEQ_GAP))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            start_q      <= 1'b0;
            tx_data_q    <= 16'h0000;
            reg_idx_q    <= 4'd0;
            retry_cnt_q  <= 2'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            retry_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            tx_data_q    <= tx_data_d;
            reg_idx_q    <= reg_idx_d;
            retry_cnt_q  <= retry_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
            retry_pend_q <= retry_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign tx_go     = (state_q == SEQ_ISSUE) && !tx_busy;
    assign tx_addr   = {DEV_ADDR, TX_WR_BIT};
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != SEQ_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign reg_idx   = reg_idx_q;
    assign retry_cnt = retry_cnt_q;

endmodule
